// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the forwarding/hazard controller.
// master: pipeline (drives stage info, consumes selects/stall)
// slave : fwd_hazard_ctrl
interface fwd_hazard_ctrl_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 16
);
  // ID stage
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [AW-1:0] id_rd;
  logic          id_reg_wr;
  logic          id_is_mc;
  // ID/EX
  logic          ex_valid;
  logic          ex_is_load;
  logic          ex_reg_wr;
  logic [AW-1:0] ex_rd;
  logic [AW-1:0] ex_rs1;
  logic [AW-1:0] ex_rs2;
  // EX/MEM and MEM/WB
  logic          mem_reg_wr;
  logic [AW-1:0] mem_rd;
  logic          wb_reg_wr;
  logic [AW-1:0] wb_rd;
  // Multi-cycle unit
  logic          mc_issue;
  logic [AW-1:0] mc_issue_rd;
  logic          mc_done;
  logic [AW-1:0] mc_done_rd;
  logic          flush;
  // Controller outputs
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall;
  logic [1:0]       stall_cause;
  logic [NREG-1:0]  sb_pending;
  logic [2:0]       mc_outstanding;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_wr, id_is_mc,
           ex_valid, ex_is_load, ex_reg_wr, ex_rd, ex_rs1, ex_rs2,
           mem_reg_wr, mem_rd, wb_reg_wr, wb_rd,
           mc_issue, mc_issue_rd, mc_done, mc_done_rd, flush,
    input  fwd_a, fwd_b, stall, stall_cause, sb_pending, mc_outstanding,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_wr, id_is_mc,
           ex_valid, ex_is_load, ex_reg_wr, ex_rd, ex_rs1, ex_rs2,
           mem_reg_wr, mem_rd, wb_reg_wr, wb_rd,
           mc_issue, mc_issue_rd, mc_done, mc_done_rd, flush,
    output fwd_a, fwd_b, stall, stall_cause, sb_pending, mc_outstanding,
           stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use / scoreboard / MC-full stall generation,
// register scoreboard for multi-cycle ops and a saturating stall counter.
module fwd_hazard_ctrl #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned MC_MAX = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  fwd_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_LU   = 2'b01,
    CAUSE_SB   = 2'b10,
    CAUSE_MCF  = 2'b11
  } cause_e;

  localparam logic [2:0] MC_MAX_L = 3'(MC_MAX);

  logic [NREG-1:0]  sb_q, sb_d;
  logic [2:0]       mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  fwd_e   fwd_a, fwd_b;
  cause_e cause;
  logic   id_act, rs1_chk, rs2_chk;
  logic   lu_haz, sb_haz, mcf_haz, stall;
  logic   done_eff;

  // Operand forward selects: EX/MEM result beats the older MEM/WB result
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (bus.mem_reg_wr && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs1))
      fwd_a = FWD_MEM;
    else if (bus.wb_reg_wr && (bus.wb_rd != '0) && (bus.wb_rd == bus.ex_rs1))
      fwd_a = FWD_WB;
    if (bus.mem_reg_wr && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs2))
      fwd_b = FWD_MEM;
    else if (bus.wb_reg_wr && (bus.wb_rd != '0) && (bus.wb_rd == bus.ex_rs2))
      fwd_b = FWD_WB;
  end

  // Hazard terms from the ID instruction; a flushed ID slot raises none
  always_comb begin
    id_act  = bus.id_valid && !bus.flush;
    rs1_chk = bus.id_rs1_used && (bus.id_rs1 != '0);
    rs2_chk = bus.id_rs2_used && (bus.id_rs2 != '0);

    lu_haz = id_act && bus.ex_valid && bus.ex_is_load && bus.ex_reg_wr &&
             (bus.ex_rd != '0) &&
             ((rs1_chk && (bus.ex_rd == bus.id_rs1)) ||
              (rs2_chk && (bus.ex_rd == bus.id_rs2)));

    sb_haz = id_act &&
             ((rs1_chk && sb_q[bus.id_rs1]) ||
              (rs2_chk && sb_q[bus.id_rs2]) ||
              (bus.id_reg_wr && (bus.id_rd != '0) && sb_q[bus.id_rd]));

    mcf_haz = id_act && bus.id_is_mc && (mc_cnt_q == MC_MAX_L);

    stall = lu_haz || sb_haz || mcf_haz;
  end

  // Stall cause, highest priority first
  always_comb begin
    cause = CAUSE_NONE;
    if (lu_haz)       cause = CAUSE_LU;
    else if (sb_haz)  cause = CAUSE_SB;
    else if (mcf_haz) cause = CAUSE_MCF;
  end

  // Next state for scoreboard, in-flight count and stall counter
  always_comb begin
    sb_d = sb_q;
    if (bus.mc_done) sb_d[bus.mc_done_rd] = 1'b0;
    // set applied after clear so a same-register issue wins
    if (bus.mc_issue && (bus.mc_issue_rd != '0)) sb_d[bus.mc_issue_rd] = 1'b1;
    sb_d[0] = 1'b0;

    // a completion with nothing in flight is ignored; an issue paired with
    // a real completion leaves the count unchanged
    done_eff = bus.mc_done && (mc_cnt_q != '0);
    mc_cnt_d = mc_cnt_q;
    if (bus.mc_issue && !done_eff) begin
      if (mc_cnt_q != MC_MAX_L) mc_cnt_d = mc_cnt_q + 3'd1;
    end else if (!bus.mc_issue && done_eff) begin
      mc_cnt_d = mc_cnt_q - 3'd1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q        <= '0;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Drive the interface outputs
  always_comb begin
    bus.fwd_a          = fwd_a;
    bus.fwd_b          = fwd_b;
    bus.stall          = stall;
    bus.stall_cause    = cause;
    bus.sb_pending     = sb_q;
    bus.mc_outstanding = mc_cnt_q;
    bus.stall_cnt      = stall_cnt_q;
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl; expectations are queued as
// stimulus is applied and compared once outputs have settled.
module tb_fwd_hazard_ctrl;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 4;

  localparam int S_FWDA = 0, S_FWDB = 1, S_STALL = 2, S_CAUSE = 3,
                 S_SB = 4, S_MC = 5, S_SCNT = 6;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_sc   = 0;
  exp_t exp_q[$];

  fwd_hazard_ctrl_if #(.AW(AW), .NREG(NREG), .CNT_W(CNT_W)) bus ();

  fwd_hazard_ctrl #(.NREG(NREG), .AW(AW), .MC_MAX(2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_FWDA:  return 32'(bus.fwd_a);
      S_FWDB:  return 32'(bus.fwd_b);
      S_STALL: return 32'(bus.stall);
      S_CAUSE: return 32'(bus.stall_cause);
      S_SB:    return 32'(bus.sb_pending);
      S_MC:    return 32'(bus.mc_outstanding);
      S_SCNT:  return 32'(bus.stall_cnt);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  // settle combinational outputs then compare every queued expectation
  task automatic drain();
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0; bus.id_rd = 0;
    bus.id_reg_wr = 0; bus.id_is_mc = 0;
    bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_reg_wr = 0;
    bus.ex_rd = 0; bus.ex_rs1 = 0; bus.ex_rs2 = 0;
    bus.mem_reg_wr = 0; bus.mem_rd = 0; bus.wb_reg_wr = 0; bus.wb_rd = 0;
    bus.mc_issue = 0; bus.mc_issue_rd = 0; bus.mc_done = 0; bus.mc_done_rd = 0;
    bus.flush = 0;
  endtask

  task automatic set_load_use();
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_reg_wr = 1; bus.ex_rd = 7;
    bus.id_valid = 1; bus.id_rs2 = 7; bus.id_rs2_used = 1;
  endtask

  initial begin
    clear_in();
    rst = 1;
    tick();
    tick();
    rst = 0;

    // reset state
    push("rst_fwd_a", S_FWDA, 0);
    push("rst_fwd_b", S_FWDB, 0);
    push("rst_stall", S_STALL, 0);
    push("rst_cause", S_CAUSE, 0);
    push("rst_sb", S_SB, 0);
    push("rst_mc", S_MC, 0);
    push("rst_scnt", S_SCNT, 0);
    drain();

    // forwarding priority
    bus.mem_reg_wr = 1; bus.mem_rd = 5; bus.wb_reg_wr = 1; bus.wb_rd = 5;
    bus.ex_rs1 = 5; bus.ex_rs2 = 5;
    push("fwd_a_mem", S_FWDA, 2);
    push("fwd_b_mem", S_FWDB, 2);
    drain();
    bus.mem_reg_wr = 0;
    push("fwd_a_wb", S_FWDA, 1);
    drain();
    bus.ex_rs1 = 0;
    push("fwd_a_x0", S_FWDA, 0);
    push("fwd_b_wb", S_FWDB, 1);
    drain();
    bus.mem_reg_wr = 1; bus.mem_rd = 0;
    push("fwd_b_memx0", S_FWDB, 1);
    drain();
    clear_in();

    // load-use: unused source does not stall
    set_load_use();
    bus.id_rs2_used = 0;
    push("lu_unused", S_STALL, 0);
    drain();
    bus.id_rs2_used = 1;
    push("lu_stall", S_STALL, 1);
    push("lu_cause", S_CAUSE, 1);
    drain();
    tick(); exp_sc++;
    clear_in();
    bus.wb_reg_wr = 1; bus.wb_rd = 7; bus.ex_rs2 = 7;
    push("lu_after_stall", S_STALL, 0);
    push("lu_after_cause", S_CAUSE, 0);
    push("lu_fwd_b", S_FWDB, 1);
    push("lu_scnt", S_SCNT, 32'(exp_sc));
    drain();
    clear_in();

    // flush suppresses load-use
    set_load_use();
    bus.flush = 1;
    push("flush_stall", S_STALL, 0);
    push("flush_cause", S_CAUSE, 0);
    drain();
    tick();
    push("flush_scnt", S_SCNT, 32'(exp_sc));
    drain();
    clear_in();

    // scoreboard RAW
    bus.mc_issue = 1; bus.mc_issue_rd = 9;
    tick();
    bus.mc_issue = 0;
    bus.id_valid = 1; bus.id_rs1 = 9; bus.id_rs1_used = 1;
    push("sb9_set", S_SB, 32'h0000_0200);
    push("sb9_mc", S_MC, 1);
    push("raw_stall", S_STALL, 1);
    push("raw_cause", S_CAUSE, 2);
    drain();
    tick(); exp_sc++;
    bus.mc_done = 1; bus.mc_done_rd = 9;
    push("raw_doneN_stall", S_STALL, 1);
    push("raw_doneN_cause", S_CAUSE, 2);
    drain();
    tick(); exp_sc++;
    bus.mc_done = 0;
    push("raw_N1_stall", S_STALL, 0);
    push("raw_N1_sb", S_SB, 0);
    push("raw_N1_mc", S_MC, 0);
    push("raw_scnt", S_SCNT, 32'(exp_sc));
    drain();
    clear_in();

    // MC full and cause priority
    bus.mc_issue = 1; bus.mc_issue_rd = 10;
    tick();
    bus.mc_issue_rd = 11;
    tick();
    bus.mc_issue = 0;
    bus.id_valid = 1; bus.id_is_mc = 1; bus.id_rs1 = 1; bus.id_rs1_used = 1;
    bus.id_rd = 12; bus.id_reg_wr = 1;
    push("full_mc", S_MC, 2);
    push("full_sb", S_SB, 32'h0000_0c00);
    push("full_stall", S_STALL, 1);
    push("full_cause", S_CAUSE, 3);
    drain();
    bus.id_rd = 11;
    push("waw_over_full", S_CAUSE, 2);
    drain();
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_reg_wr = 1; bus.ex_rd = 1;
    push("lu_over_sb", S_CAUSE, 1);
    drain();
    clear_in();
    bus.mc_issue = 1; bus.mc_issue_rd = 12; bus.mc_done = 1; bus.mc_done_rd = 10;
    tick();
    push("issue_done_mc", S_MC, 2);
    push("issue_done_sb", S_SB, 32'h0000_1800);
    drain();
    bus.mc_issue_rd = 11; bus.mc_done_rd = 11;
    tick();
    push("set_wins_sb", S_SB, 32'h0000_1800);
    push("set_wins_mc", S_MC, 2);
    push("full_scnt", S_SCNT, 32'(exp_sc));
    drain();
    clear_in();

    // reset mid-operation
    rst = 1;
    tick();
    rst = 0;
    exp_sc = 0;
    push("midrst_sb", S_SB, 0);
    push("midrst_mc", S_MC, 0);
    push("midrst_scnt", S_SCNT, 0);
    drain();
    bus.mc_done = 1; bus.mc_done_rd = 5;
    tick();
    bus.mc_done = 0;
    push("done_at0_mc", S_MC, 0);
    drain();

    // x0 destination never marked pending
    bus.mc_issue = 1; bus.mc_issue_rd = 0;
    tick();
    bus.mc_issue = 0;
    bus.id_valid = 1; bus.id_rs1 = 0; bus.id_rs1_used = 1;
    bus.id_rd = 0; bus.id_reg_wr = 1;
    push("x0_sb", S_SB, 0);
    push("x0_mc", S_MC, 1);
    push("x0_stall", S_STALL, 0);
    drain();
    clear_in();

    // stall counter saturation
    set_load_use();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp_sc < (1 << CNT_W) - 1) exp_sc++;
      push("sat_scnt", S_SCNT, 32'(exp_sc));
      drain();
    end
    clear_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised next-generation forwarding and hazard controller for the 5-stage RV32I pipeline.
- Generates the EX-stage operand forward selects with the existing EX/MEM-over-MEM/WB priority.
- Adds load-use stall detection and a register scoreboard for long-latency (multi-cycle) ops, including RAW/WAW stalls and an outstanding-op limit.
- Adds a stall-cause output and a saturating stall-cycle counter.
- Sits beside the hazard logic between the ID/EX pipeline register and the EX operand muxes.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register index width; NREG = 2**AW.
- MC_MAX, 2, maximum outstanding multi-cycle ops (1..7).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1, id_rs2  in  AW  ID source registers.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd  in  AW  ID destination.
- id_reg_wr  in  1  ID instruction writes id_rd.
- id_is_mc  in  1  ID instruction is a multi-cycle op.
- ex_valid, ex_is_load, ex_reg_wr  in  1  ID/EX stage info.
- ex_rd, ex_rs1, ex_rs2  in  AW  ID/EX registers.
- mem_reg_wr  in  1  EX/MEM write enable.
- mem_rd  in  AW  EX/MEM destination.
- wb_reg_wr  in  1  MEM/WB write enable.
- wb_rd  in  AW  MEM/WB destination.
- mc_issue  in  1  multi-cycle op leaves EX into the MC unit this cycle.
- mc_issue_rd  in  AW  its destination.
- mc_done  in  1  MC unit writes back this cycle.
- mc_done_rd  in  AW  its destination.
- flush  in  1  branch/jump flush of IF/ID.
- fwd_a, fwd_b  out  2  00 regfile, 10 EX/MEM, 01 MEM/WB.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- stall_cause  out  2  00 none, 01 load-use, 10 scoreboard, 11 MC full.
- sb_pending  out  NREG  scoreboard bit per register.
- mc_outstanding  out  3  count of in-flight MC ops.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- **Reset (rst=1 at edge):**
  - sb_pending=0, mc_outstanding=0, stall_cnt=0.
  - Combinational outputs follow their inputs; with reset state and no hazards: fwd=00, stall=0, cause=00.
- **Forwarding (combinational, zero latency):**
  - fwd_a=10 if mem_reg_wr & mem_rd!=0 & mem_rd==ex_rs1.
  - Else fwd_a=01 if wb_reg_wr & wb_rd!=0 & wb_rd==ex_rs1.
  - Else fwd_a=00.
  - fwd_b is identical using ex_rs2.
- **Hazard terms** (all gated by id_valid & !flush; a source term requires rsN_used & rsN!=0):
  - LU: ex_valid & ex_is_load & ex_reg_wr & ex_rd!=0 & ex_rd matches a used source.
  - SB (RAW): sb_pending[rsN] for a used source.
  - SB (WAW): id_reg_wr & id_rd!=0 & sb_pending[id_rd].
  - MCF: id_is_mc & (mc_outstanding == MC_MAX).
- **Stall priority:**
  - stall = LU | SB | MCF.
  - stall_cause reports the highest-priority term: LU > SB > MCF.
  - A load-use stall lasts exactly one cycle; next cycle the load is in MEM/WB and is forwarded via 01.
- **Scoreboard (registered):**
  - On mc_issue with mc_issue_rd!=0, set the bit.
  - On mc_done, clear bit mc_done_rd.
  - Same-register set and clear in one cycle: set wins. WAW stall makes this legal only when a new op follows completion.
  - Bit 0 is never set.
  - Clear is visible the cycle after mc_done, so the dependent instruction issues one cycle after writeback; no same-cycle regfile bypass is required.
- **mc_outstanding:**
  - +1 on mc_issue, -1 on mc_done, unchanged on both.
  - Never exceeds MC_MAX or goes below 0; mc_done at 0 is ignored.
- **flush:**
  - Suppresses ID-based stall terms in the same cycle.
  - Does not clear the scoreboard or mc_outstanding; in-flight MC ops still write back.
- **stall_cnt:** increments each cycle stall=1; saturates at all-ones.
- **rst mid-operation:** all registered state returns to reset values at the edge regardless of pending mc_done.

Test Plan:
- **EX/MEM vs MEM/WB priority:** mem_rd=5/wr=1, wb_rd=5/wr=1, ex_rs1=5 -> fwd_a=10. Then mem_reg_wr=0 -> fwd_a=01. Then ex_rs1=0 -> fwd_a=00.
- **Load-use:** ex_is_load=1, ex_rd=7, id_rs2=7 used -> stall=1, cause=01 for one cycle; stall_cnt=1. Next cycle, with ex_valid=0, wb_rd=7 and ex_rs2=7 -> fwd_b=01.
- **Scoreboard RAW:** mc_issue with rd=9, then ID reads x9 -> stall=1, cause=10, sb_pending[9]=1. mc_done rd=9 at cycle N -> stall still 1 at N, 0 at N+1.
- **MC full with MC_MAX=2:** two issues -> mc_outstanding=2; ID mc op with unrelated regs -> cause=11. Simultaneous mc_issue+mc_done -> count stays 2.
- **x0 and flush:** mc_issue rd=0 -> sb_pending stays 0. Load-use hazard with flush=1 -> stall=0, stall_cnt unchanged.
- **Reset mid-op:** two pending ops, rst=1 for one edge -> sb_pending=0, mc_outstanding=0, stall_cnt=0. A later mc_done at count 0 -> count stays 0.
